// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program image into a RAM and releases the CPU
// once the image checksum matches.
//
// Stream format: length byte N, then N data bytes, then one checksum byte. The checksum
// is the 8-bit wrapping sum of the data bytes only; the length byte is not included.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   restart    reload request, honoured only after a load has finished (ok or error)
//   in_valid   incoming byte valid
//   in_data    incoming byte
//   in_ready   loader can accept a byte this cycle
//   write_req  one-cycle RAM write strobe, one cycle after each data byte transfer
//   w_addr     RAM write address (byte index, zero-extended)
//   w_data     RAM write data
//   cpu_hold   holds the CPU in reset; low only after a successful load
//   load_ok    last load completed with a matching checksum
//   load_err   last load failed its checksum
module prog_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_req,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              cpu_hold,
    output logic              load_ok,
    output logic              load_err
);

    typedef enum logic [2:0] {
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic              write_req_q, write_req_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_ok_q, load_ok_d;
    logic        load_err_q, load_err_d;

    logic        xfer;
    logic [7:0]  in_byte;

    assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign xfer     = in_valid && in_ready;
    // Length and checksum arithmetic is always 8 bits wide, whatever DATA_W is.
    assign in_byte  = 8'(in_data);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        write_req_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;

        case (state_q)
            StLen: begin
                if (xfer) begin
                    len_d   = in_byte;
                    idx_d   = 8'd0;
                    sum_d   = 8'd0;
                    state_d = (in_byte == 8'd0) ? StCsum : StData;
                end
            end
            StData: begin
                if (xfer) begin
                    sum_d       = sum_q + in_byte;
                    idx_d       = idx_q + 8'd1;
                    write_req_d = 1'b1;
                    w_addr_d    = ADDR_W'(idx_q);
                    w_data_d    = in_data;
                    // len_q is non-zero here, so len_q - 1 never wraps.
                    if (idx_q == len_q - 8'd1) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = (in_byte == sum_q) ? StDone : StErr;
                end
            end
            StDone, StErr: begin
                if (restart) begin
                    state_d = StLen;
                end
            end
            default: state_d = StLen;
        endcase

        // Status flags are registered copies of the next state so they are glitch-free.
        cpu_hold_d = (state_d != StDone);
        load_ok_d  = (state_d == StDone);
        load_err_d = (state_d == StErr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StLen;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            sum_q       <= 8'd0;
            write_req_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            cpu_hold_q  <= 1'b1;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            write_req_q <= write_req_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_ok_q   <= load_ok_d;
            load_err_q  <= load_err_d;
        end
    end

    assign write_req = write_req_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_ok   = load_ok_q;
    assign load_err  = load_err_q;

endmodule
